// File: rtl/hazard_unit_pkg.sv
// rtl/hazard_unit_pkg.sv - shared state encodings for the pipeline hazard controller
package hazard_unit_pkg;

    // Memory-wait watchdog FSM states.
    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        FAULT    = 2'b10
    } hu_state_e;

endpackage

// File: rtl/hazard_event_counter.sv
// rtl/hazard_event_counter.sv - wrapping event counter with synchronous clear
// Ports:
//   clk, reset  : core clock, synchronous active-high reset
//   clear       : synchronous clear, wins over incr
//   incr        : count one event this cycle
//   count       : current count, wraps modulo 2^WIDTH
module hazard_event_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             incr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (incr) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use / mispredict / memory-wait hazard controller
// Ports:
//   clk, reset                      : core clock, synchronous active-high reset
//   ID_rs1/2, ID_rs1/2_used         : decode-stage sources and whether they are read
//   EX_rd, EX_memory_read           : execute-stage destination and load flag
//   EX_jump, EX_branch, EX_branch_taken, EX_branch_estimation : control-flow resolution in EX
//   MEM_memory_read/write, dmem_ready : memory-stage access and completion
//   counter_clear                   : synchronous clear of both performance counters
//   *_stall, *_flush, mispredict    : combinational pipeline controls
//   mem_fault                       : sticky memory-timeout fault
//   stall_count, flush_count        : performance counters
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int MEM_TIMEOUT   = 255,
    parameter int TIMEOUT_WIDTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      ID_rs1,
    input  logic [4:0]      ID_rs2,
    input  logic            ID_rs1_used,
    input  logic            ID_rs2_used,
    input  logic [4:0]      EX_rd,
    input  logic            EX_memory_read,
    input  logic            EX_jump,
    input  logic            EX_branch,
    input  logic            EX_branch_taken,
    input  logic            EX_branch_estimation,
    input  logic            MEM_memory_read,
    input  logic            MEM_memory_write,
    input  logic            dmem_ready,
    input  logic            counter_clear,
    output logic            PC_stall,
    output logic            IF_ID_stall,
    output logic            ID_EX_stall,
    output logic            EX_MEM_stall,
    output logic            IF_ID_flush,
    output logic            ID_EX_flush,
    output logic            mispredict,
    output logic            mem_fault,
    output logic [XLEN-1:0] stall_count,
    output logic [XLEN-1:0] flush_count
);

    hu_state_e                state_q, state_d;
    logic [TIMEOUT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;

    logic load_use;
    logic mispredict_raw;
    logic mem_wait;

    // x0 is never a real producer, so a load targeting it cannot create a hazard.
    assign load_use = EX_memory_read && (EX_rd != 5'd0) &&
                      ((ID_rs1_used && (ID_rs1 == EX_rd)) ||
                       (ID_rs2_used && (ID_rs2 == EX_rd)));

    assign mispredict_raw = EX_jump || (EX_branch && (EX_branch_taken != EX_branch_estimation));

    assign mem_wait = (MEM_memory_read || MEM_memory_write) && !dmem_ready;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            RUN: begin
                if (mem_wait) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = TIMEOUT_WIDTH'(1);
                end else begin
                    wait_cnt_d = '0;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == TIMEOUT_WIDTH'(MEM_TIMEOUT)) begin
                    state_d = FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + TIMEOUT_WIDTH'(1);
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // A held EX stage defers any redirect; the mispredict is seen again once the
    // memory wait releases, so stalls take priority over flushes.
    always_comb begin
        PC_stall     = 1'b0;
        IF_ID_stall  = 1'b0;
        ID_EX_stall  = 1'b0;
        EX_MEM_stall = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        mispredict   = 1'b0;
        if (!reset) begin
            if ((state_q == FAULT) || mem_wait) begin
                PC_stall     = 1'b1;
                IF_ID_stall  = 1'b1;
                ID_EX_stall  = 1'b1;
                EX_MEM_stall = 1'b1;
            end else if (mispredict_raw) begin
                IF_ID_flush = 1'b1;
                ID_EX_flush = 1'b1;
                mispredict  = 1'b1;
            end else if (load_use) begin
                PC_stall    = 1'b1;
                IF_ID_stall = 1'b1;
                ID_EX_flush = 1'b1;
            end
        end
    end

    assign mem_fault = (state_q == FAULT);

    hazard_event_counter #(.WIDTH(XLEN)) u_stall_counter (
        .clk   (clk),
        .reset (reset),
        .clear (counter_clear),
        .incr  (PC_stall && (state_q != FAULT)),
        .count (stall_count)
    );

    hazard_event_counter #(.WIDTH(XLEN)) u_flush_counter (
        .clk   (clk),
        .reset (reset),
        .clear (counter_clear),
        .incr  (mispredict),
        .count (flush_count)
    );

endmodule
